button_event_scheduler: RTL and testbench

Turns the debouncer's per-button levels into a single serialized stream of press events. It detects rising edges on each debounced line, holds one pending event per button, and shares one valid/ready output between all buttons using round-robin arbitration. It sits between the debouncer and its consumer (FIFO, UART TX, or a control FSM). Optionally, it generates auto-repeat events while a button is held.

---
 rtl/button_event_scheduler_pkg.sv | 23 ++
 rtl/button_event_scheduler_rr_arbiter.sv | 47 ++++
 rtl/button_event_scheduler.sv | 147 ++++++++++++++
 tb/tb_button_event_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_scheduler_pkg.sv
// ============================================================================
// Module   : button_event_scheduler_pkg
// Brief    : Shared FSM state encoding and event-ID width helper for the
//            button scheduler and the debouncer wrapper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_event_scheduler_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  // Event index width; a single button still needs one ID bit.
  function automatic int id_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_event_scheduler_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; the search starts one past
//            the last granted index and wraps to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import button_event_scheduler_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int IDW   = id_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  input  logic [IDW-1:0]   last_i,
  output logic [WIDTH-1:0] gnt_o,
  output logic [IDW-1:0]   idx_o,
  output logic             any_o
);

  int               w_cand;
  logic [WIDTH-1:0] w_onehot;
  logic             w_found;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    w_found  = 1'b0;
    w_cand   = 0;
    w_onehot = '0;
    for (int k = 1; k <= WIDTH; k++) begin
      w_cand   = (int'(last_i) + k) % WIDTH;
      w_onehot = WIDTH'(1) << w_cand;
      if (!w_found && |(req_i & w_onehot)) begin
        w_found = 1'b1;
        gnt_o   = w_onehot;
        idx_o   = IDW'(w_cand);
      end
    end
  end

  assign any_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/button_event_scheduler.sv
// ============================================================================
// Module   : button_event_scheduler
// Brief    : Serialises debounced button presses into one valid/ready event
//            stream with round-robin arbitration. Auto-repeat is built only
//            when BUTTON_AUTO_REPEAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_event_scheduler
  import button_event_scheduler_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           debounced_signal,
  output logic                       event_valid,
  input  logic                       event_ready,
  output logic [id_width(WIDTH)-1:0] event_id,
  output logic                       event_repeat,
  output logic [WIDTH-1:0]           overrun
);

  localparam int IDW = id_width(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] prev_q, pending_q, pending_d, overrun_q, overrun_d;
  logic [IDW-1:0]   last_q, id_q;
  logic             valid_q;

  logic [WIDTH-1:0] w_rise, w_tick, w_set, w_clr, w_gnt;
  logic [IDW-1:0]   w_idx;
  logic             w_any, w_load;

  rr_arbiter #(
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) u_arb (
    .req_i  (pending_q),
    .last_i (last_q),
    .gnt_o  (w_gnt),
    .idx_o  (w_idx),
    .any_o  (w_any)
  );

  // The output register is free in IDLE, or in OFFER at the handshake edge.
  always_comb begin
    w_rise    = debounced_signal & ~prev_q;
    w_set     = w_rise | w_tick;
    w_load    = w_any && ((state_q == ST_IDLE) || event_ready);
    w_clr     = w_load ? w_gnt : '0;
    pending_d = w_set | (pending_q & ~w_clr);
    overrun_d = overrun_q | (w_set & pending_q & ~w_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      id_q      <= '0;
      last_q    <= IDW'(WIDTH - 1);
      prev_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      prev_q    <= debounced_signal;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      case (state_q)
        ST_IDLE: begin
          if (w_load) begin
            state_q <= ST_OFFER;
            valid_q <= 1'b1;
            id_q    <= w_idx;
            last_q  <= w_idx;
          end
        end
        ST_OFFER: begin
          if (w_load) begin
            id_q   <= w_idx;
            last_q <= w_idx;
          end else if (event_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int CNT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [CNT_W-1:0] C_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] C_WRAP  = CNT_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);

  logic [WIDTH-1:0] pend_rep_q;
  logic             rep_q;

  // Hold counters cycle DELAY..WRAP so a tick recurs every PERIOD cycles.
  for (genvar i = 0; i < WIDTH; i++) begin : g_repeat
    logic [CNT_W-1:0] hold_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= '0;
      end else if (!debounced_signal[i]) begin
        hold_q <= '0;
      end else if (hold_q == C_WRAP) begin
        hold_q <= C_DELAY;
      end else begin
        hold_q <= hold_q + 1'b1;
      end
    end
    assign w_tick[i] = debounced_signal[i] && (hold_q == C_DELAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rep_q <= '0;
      rep_q      <= 1'b0;
    end else begin
      pend_rep_q <= (pend_rep_q & ~w_set) | (w_tick & ~w_rise);
      if (w_load) begin
        rep_q <= |(pend_rep_q & w_gnt);
      end
    end
  end

  assign event_repeat = rep_q;
`else
  assign w_tick       = '0;
  assign event_repeat = 1'b0;
`endif

  assign event_valid = valid_q;
  assign event_id    = id_q;
  assign overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_button_event_scheduler.sv
// ============================================================================
// Module   : tb_button_event_scheduler
// Brief    : Scoreboard bench for button_event_scheduler (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_event_scheduler;

  localparam int W = 4;

  typedef struct packed {
    logic [1:0] id;
    logic       rep;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] lines = '0;
  logic         ready = 1'b0;
  logic         valid;
  logic         rep;
  logic [1:0]   id;
  logic [W-1:0] ovr;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  button_event_scheduler #(
    .WIDTH         (W),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .debounced_signal (lines),
    .event_valid      (valid),
    .event_ready      (ready),
    .event_id         (id),
    .event_repeat     (rep),
    .overrun          (ovr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input logic [1:0] eid, input logic erep);
    exp_q.push_back(exp_t'{eid, erep});
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || valid) && n < 60) begin
      tick();
      n++;
    end
    check(nm, exp_q.size(), 0);
  endtask

  // Lines high for two edges, then low; ready toggles every cycle.
  task automatic rr_round(input logic [W-1:0] pat);
    lines = pat;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 1) lines = '0;
      ready = ~ready;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got id=%0d rep=%0d expected none", id, rep);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_id", 32'(id), 32'(e.id));
        check("event_repeat", 32'(rep), 32'(e.rep));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    check("rst_valid", valid, 0);
    check("rst_id", id, 0);
    check("rst_repeat", rep, 0);
    check("rst_overrun", ovr, 0);
    rst_n = 1'b1;
    ready = 1'b1;
    tick(2);

    // single press: valid exactly two edges later, for one cycle
    expect_ev(2'd0, 1'b0);
    lines = 4'b0001;
    tick();
    check("press_t0_valid", valid, 0);
    tick();
    check("press_t1_valid", valid, 1);
    check("press_t1_id", id, 0);
    check("press_t1_repeat", rep, 0);
    tick();
    check("press_t2_valid", valid, 0);
    tick(8);
    check("press_hold_quiet", valid, 0);
    lines = '0;
    tick(2);

    // backpressure: buttons 1 and 3 together, ready low for 10 cycles
    ready = 1'b0;
    expect_ev(2'd1, 1'b0);
    expect_ev(2'd3, 1'b0);
    lines = 4'b1010;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", valid, 1);
      check("bp_id", id, 1);
      tick();
    end
    ready = 1'b1;
    tick();
    check("bp_next_valid", valid, 1);
    check("bp_next_id", id, 3);
    tick();
    check("bp_done_valid", valid, 0);
    lines = '0;
    tick(2);

    // round-robin fairness, including a wrap from a non-zero start
    expect_ev(2'd0, 1'b0); expect_ev(2'd1, 1'b0); expect_ev(2'd2, 1'b0); expect_ev(2'd3, 1'b0);
    rr_round(4'b1111);
    expect_ev(2'd2, 1'b0);
    rr_round(4'b0100);
    expect_ev(2'd3, 1'b0); expect_ev(2'd0, 1'b0); expect_ev(2'd1, 1'b0); expect_ev(2'd2, 1'b0);
    rr_round(4'b1111);
    expect_ev(2'd3, 1'b0); expect_ev(2'd0, 1'b0); expect_ev(2'd1, 1'b0); expect_ev(2'd2, 1'b0);
    rr_round(4'b1111);
    drain("rr_drain");
    check("rr_no_overrun", ovr, 0);

    // coalescing: button 3 holds the output, button 0 pressed twice
    ready = 1'b0;
    expect_ev(2'd3, 1'b0);
    expect_ev(2'd0, 1'b0);
    lines = 4'b1000;
    tick(2);
    check("co_valid", valid, 1);
    check("co_id", id, 3);
    lines = 4'b1001;
    tick();
    check("co_first_overrun", ovr, 0);
    lines = 4'b1000;
    tick();
    lines = 4'b1001;
    tick();
    check("co_overrun", ovr, 4'b0001);
    ready = 1'b1;
    tick();
    check("co_next_id", id, 0);
    check("co_next_valid", valid, 1);
    tick();
    check("co_done_valid", valid, 0);
    lines = '0;
    tick(3);
    check("co_overrun_sticky", ovr, 4'b0001);
    check("co_queue", exp_q.size(), 0);

    // reset while offering with two events still pending
    ready = 1'b0;
    lines = 4'b0111;
    tick(2);
    check("rm_valid_before", valid, 1);
    check("rm_id_before", id, 1);
    rst_n = 1'b0;
    lines = '0;
    #1;
    check("rm_valid", valid, 0);
    check("rm_id", id, 0);
    check("rm_overrun", ovr, 0);
    tick(2);
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rm_quiet", valid, 0);
    end

    // first grant after reset favours button 0
    expect_ev(2'd0, 1'b0);
    expect_ev(2'd3, 1'b0);
    lines = 4'b1001;
    tick(2);
    check("post_rst_id", id, 0);
    lines = '0;
    drain("post_rst_drain");

`ifdef BUTTON_AUTO_REPEAT_EN
    // hold button 1 for 40 cycles: press, then repeats at +20, +28, +36
    expect_ev(2'd1, 1'b0);
    expect_ev(2'd1, 1'b1);
    expect_ev(2'd1, 1'b1);
    expect_ev(2'd1, 1'b1);
    lines = 4'b0010;
    tick();
    tick(20);
    check("ar_before_first", valid, 0);
    tick();
    check("ar_first_valid", valid, 1);
    check("ar_first_repeat", rep, 1);
    check("ar_first_id", id, 1);
    tick(18);
    lines = '0;
    tick(20);
    check("ar_after_release", valid, 0);
    drain("ar_drain");
`endif

    drain("final_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
